// File: rtl/swipt_link_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : swipt_link_pkg                                               |
// | Description : Shared definitions for the SWIPT downlink receive path:      |
// |               frame delimiters, frame length, receiver FSM states and a    |
// |               small bit-count helper.                                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package swipt_link_pkg;

  // Frame delimiters, sent MSB first
  localparam logic [5:0] PREAMBLE   = 6'b101010;
  localparam logic [3:0] TRAILER    = 4'b0101;
  localparam int         FRAME_BITS = 23;

  // Receiver FSM states, explicitly encoded
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RECV  = 2'd2
  } rx_state_e;

  // Number of set bits in a 12-bit field, returned zero-extended to 8 bits
  function automatic logic [7:0] count_ones(input logic [11:0] v);
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < 12; i++) begin
      n = n + {7'd0, v[i]};
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/read_analyse_data_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : read_analyse_data_if                                         |
// | Description : Bundle between the link controller (master) and the         |
// |               downlink receiver (slave).                                   |
// |   master -> slave : swipt_alive, prog[1:0], read_en, adc[11:0],            |
// |                     mean_def[11:0]                                         |
// |   slave -> master : din, mode[1:0], ftype[1:0], data_in[7:0],              |
// |                     sum_checker[7:0], check_sum_bit, data_in_ready         |
// |   'program' and 'type' are SystemVerilog keywords, so those fields are     |
// |   carried as prog and ftype.                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface read_analyse_data_if;

  logic        swipt_alive;
  logic [1:0]  prog;
  logic        read_en;
  logic [11:0] adc;
  logic [11:0] mean_def;

  logic        din;
  logic [1:0]  mode;
  logic [1:0]  ftype;
  logic [7:0]  data_in;
  logic [7:0]  sum_checker;
  logic        check_sum_bit;
  logic        data_in_ready;

  modport master (
    output swipt_alive, prog, read_en, adc, mean_def,
    input  din, mode, ftype, data_in, sum_checker, check_sum_bit, data_in_ready
  );

  modport slave (
    input  swipt_alive, prog, read_en, adc, mean_def,
    output din, mode, ftype, data_in, sum_checker, check_sum_bit, data_in_ready
  );

endinterface
`default_nettype wire

// File: rtl/read_analyse_data_adc_slicer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : adc_slicer                                                   |
// | Description : Hysteresis comparator turning ADC current samples into a     |
// |               registered bit stream. Thresholds are mean_def +/- HYST,     |
// |               saturated to the 12-bit range.                               |
// |   clk        in  1  : clock                                                |
// |   i_clr      in  1  : synchronous clear, forces o_din low                  |
// |   i_adc      in  12 : unsigned current sample                              |
// |   i_mean_def in  12 : unsigned mean-current reference                      |
// |   o_din      out 1  : sliced bit, one cycle after the sample               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module adc_slicer #(
  parameter int HYST = 16
) (
  input  logic        clk,
  input  logic        i_clr,
  input  logic [11:0] i_adc,
  input  logic [11:0] i_mean_def,
  output logic        o_din
);

  localparam logic [12:0] C_HYST  = 13'(HYST);
  localparam logic [12:0] C_MAX12 = 13'd4095;

  logic [12:0] w_mean_ext;
  logic [12:0] w_upper_sum;
  logic [12:0] w_lower_diff;
  logic [11:0] w_upper;
  logic [11:0] w_lower;
  logic        r_din;

  // Thresholds are formed one bit wider so overflow/underflow can be clamped
  assign w_mean_ext   = {1'b0, i_mean_def};
  assign w_upper_sum  = w_mean_ext + C_HYST;
  assign w_lower_diff = w_mean_ext - C_HYST;
  assign w_upper      = (w_upper_sum > C_MAX12) ? 12'd4095 : w_upper_sum[11:0];
  assign w_lower      = (w_mean_ext < C_HYST)   ? 12'd0    : w_lower_diff[11:0];

  // Inside the hysteresis band the previous decision is kept
  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_din <= 1'b0;
    end else if (i_adc > w_upper) begin
      r_din <= 1'b1;
    end else if (i_adc < w_lower) begin
      r_din <= 1'b0;
    end
  end

  assign o_din = r_din;

endmodule
`default_nettype wire

// File: rtl/read_analyse_data.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : read_analyse_data                                            |
// | Description : SWIPT downlink receiver. Slices ADC samples into a bit       |
// |               stream, locks to the first rising edge after a low line,     |
// |               samples each bit near its centre and deserialises one        |
// |               23-bit frame: preamble 101010, mode[1:0], type[1:0],         |
// |               data[7:0], even parity over data, trailer 0101.              |
// |   clk   in : clock                                                         |
// |   nrst  in : synchronous active-low reset                                  |
// |   bus      : read_analyse_data_if.slave (inputs swipt_alive, prog,         |
// |              read_en, adc, mean_def; outputs din, mode, ftype, data_in,    |
// |              sum_checker, check_sum_bit, data_in_ready)                    |
// | Parameters  : BIT_CYCLES - clock cycles per bit                            |
// |               HYST       - slicer hysteresis in ADC LSBs                   |
// | Build macro : READ_ANALYSE_RESYNC_EN - when defined, every din transition  |
// |               while receiving re-centres the bit sampling point.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module read_analyse_data
  import swipt_link_pkg::*;
#(
  parameter int BIT_CYCLES = 200000,
  parameter int HYST       = 16
) (
  input  logic                 clk,
  input  logic                 nrst,
  read_analyse_data_if.slave   bus
);

  localparam int                 PHASE_W      = $clog2(BIT_CYCLES);
  localparam logic [PHASE_W-1:0] C_PHASE_HALF = PHASE_W'(BIT_CYCLES / 2);
  localparam logic [PHASE_W-1:0] C_PHASE_FULL = PHASE_W'(BIT_CYCLES - 1);
  localparam logic [PHASE_W-1:0] C_PHASE_ONE  = PHASE_W'(1);
  localparam logic [4:0]         C_PRE_BITS   = 5'd6;
  localparam logic [4:0]         C_FRM_BITS   = 5'(FRAME_BITS);

  logic w_clear;
  logic w_din;
  logic w_resync;

  rx_state_e          r_state;
  logic [PHASE_W-1:0] r_phase;
  logic [4:0]         r_bit_cnt;
  logic [21:0]        r_shift;
  logic               r_din_d;

  logic [1:0]         r_mode;
  logic [1:0]         r_type;
  logic [7:0]         r_data;
  logic [7:0]         r_sum;
  logic               r_chk;
  logic               r_ready;

  logic [22:0]        w_shift_next;
  logic [4:0]         w_cnt_next;
  logic               w_frame_ok;

  // Loss of link, reset or a foreign program mode all behave as one clear
  assign w_clear = ~nrst | ~bus.swipt_alive | (bus.prog != 2'b11);

  adc_slicer #(
    .HYST (HYST)
  ) u_slicer (
    .clk        (clk),
    .i_clr      (w_clear),
    .i_adc      (bus.adc),
    .i_mean_def (bus.mean_def),
    .o_din      (w_din)
  );

`ifdef READ_ANALYSE_RESYNC_EN
  assign w_resync = (w_din != r_din_d);
`else
  assign w_resync = 1'b0;
`endif

  // The incoming bit combined with the bits collected so far; bit 0 is newest
  assign w_shift_next = {r_shift, w_din};
  assign w_cnt_next   = r_bit_cnt + 5'd1;
  assign w_frame_ok   = (w_shift_next[22:17] == PREAMBLE) &&
                        (w_shift_next[3:0]   == TRAILER);

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_state   <= IDLE;
      r_phase   <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_din_d   <= 1'b0;
      r_mode    <= '0;
      r_type    <= '0;
      r_data    <= '0;
      r_sum     <= '0;
      r_chk     <= 1'b0;
      r_ready   <= 1'b0;
    end else begin
      r_din_d <= w_din;
      r_ready <= 1'b0;
      if (!bus.read_en) begin
        // Window closed: drop any partial frame, keep decoded results
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (!w_din) begin
              r_state <= ARMED;
            end
          end
          ARMED: begin
            if (w_din && !r_din_d) begin
              r_phase   <= C_PHASE_HALF;
              r_bit_cnt <= '0;
              r_state   <= RECV;
            end
          end
          RECV: begin
            if (r_phase == '0) begin
              r_shift   <= w_shift_next[21:0];
              r_bit_cnt <= w_cnt_next;
              r_phase   <= C_PHASE_FULL;
              if ((w_cnt_next == C_PRE_BITS) && (w_shift_next[5:0] != PREAMBLE)) begin
                r_state <= IDLE;
              end else if (w_cnt_next == C_FRM_BITS) begin
                r_state <= IDLE;
                if (w_frame_ok) begin
                  r_mode  <= w_shift_next[16:15];
                  r_type  <= w_shift_next[14:13];
                  r_data  <= w_shift_next[12:5];
                  r_sum   <= count_ones(w_shift_next[16:5]);
                  r_chk   <= (w_shift_next[4] == ^w_shift_next[12:5]);
                  r_ready <= 1'b1;
                end
              end
            end else if (w_resync) begin
              r_phase <= C_PHASE_HALF;
            end else begin
              r_phase <= r_phase - C_PHASE_ONE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.din           = w_din;
  assign bus.mode          = r_mode;
  assign bus.ftype         = r_type;
  assign bus.data_in       = r_data;
  assign bus.sum_checker   = r_sum;
  assign bus.check_sum_bit = r_chk;
  assign bus.data_in_ready = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_read_analyse_data.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_read_analyse_data                                         |
// | Description : Self-checking bench for read_analyse_data. Frames are built  |
// |               from fields, sent as ADC levels, and the decoded result is   |
// |               predicted from the frame rules by a field-level model.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_read_analyse_data;
  import swipt_link_pkg::*;

  localparam int BIT_CYCLES = 16;
  localparam int HYST       = 16;
  localparam int MEAN       = 2048;

  logic clk  = 1'b0;
  logic nrst = 1'b0;

  always #5 clk = ~clk;

  read_analyse_data_if bus ();

  read_analyse_data #(
    .BIT_CYCLES (BIT_CYCLES),
    .HYST       (HYST)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int ready_cycles = 0;

  // Expected decoded outputs and slicer state
  logic [1:0] exp_mode;
  logic [1:0] exp_type;
  logic [7:0] exp_data;
  logic [7:0] exp_sum;
  logic       exp_chk;
  logic       exp_din;

  always @(negedge clk) begin
    if (bus.data_in_ready === 1'b1) ready_cycles++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    exp_mode = '0; exp_type = '0; exp_data = '0; exp_sum = '0; exp_chk = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, ".mode"},  32'(bus.mode),          32'(exp_mode));
    check_val({tag, ".type"},  32'(bus.ftype),         32'(exp_type));
    check_val({tag, ".data"},  32'(bus.data_in),       32'(exp_data));
    check_val({tag, ".sum"},   32'(bus.sum_checker),   32'(exp_sum));
    check_val({tag, ".chk"},   32'(bus.check_sum_bit), 32'(exp_chk));
  endtask

  // Hold a line level for ncyc cycles; amplitude varies per bit
  task automatic hold_bit(input logic b, input int ncyc);
    @(posedge clk); #1;
    if (b) bus.adc = 12'(MEAN + HYST + 1 + int'($urandom_range(0, 150)));
    else   bus.adc = 12'(MEAN - HYST - 1 - int'($urandom_range(0, 150)));
    repeat (ncyc - 1) @(posedge clk);
  endtask

  task automatic send_bits(input logic [22:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) hold_bit(f[22 - i], BIT_CYCLES);
  endtask

  function automatic logic [22:0] build(input logic [5:0] pre, input logic [1:0] m,
                                        input logic [1:0] t, input logic [7:0] d,
                                        input logic par, input logic [3:0] trl);
    return {pre, m, t, d, par, trl};
  endfunction

  // Full frame with idle padding long enough for the receiver to settle,
  // then verify pulse count and decoded fields against the frame rules.
  task automatic run_frame(input string tag, input logic [22:0] f);
    int r0;
    logic valid;
    r0 = ready_cycles;
    hold_bit(1'b0, 3 * BIT_CYCLES);
    send_bits(f, 23);
    hold_bit(1'b0, 26 * BIT_CYCLES);
    @(negedge clk);
    valid = (f[22:17] == PREAMBLE) && (f[3:0] == TRAILER);
    if (valid) begin
      exp_mode = f[16:15];
      exp_type = f[14:13];
      exp_data = f[12:5];
      exp_sum  = 8'($countones(f[16:5]));
      exp_chk  = (f[4] == ^f[12:5]);
    end
    check_val({tag, ".ready"}, 32'(ready_cycles - r0), valid ? 32'd1 : 32'd0);
    check_outputs(tag);
  endtask

  // Slicer reference: saturated thresholds, hold inside the band
  task automatic slice_check(input string tag, input int v, input int mean);
    int up, lo;
    up = mean + HYST; if (up > 4095) up = 4095;
    lo = mean - HYST; if (lo < 0)    lo = 0;
    if (v > up)      exp_din = 1'b1;
    else if (v < lo) exp_din = 1'b0;
    @(posedge clk); #1;
    bus.adc      = 12'(v);
    bus.mean_def = 12'(mean);
    @(posedge clk);
    @(negedge clk);
    check_val(tag, 32'(bus.din), 32'(exp_din));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got 0 expected 1");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [22:0] f;
    int r0;
    int kind;
    logic [5:0] pre;
    logic [3:0] trl;
    logic [7:0] d;
    logic [1:0] m, t;
    logic par;

    bus.swipt_alive = 1'b1;
    bus.prog        = 2'b11;
    bus.read_en     = 1'b1;
    bus.mean_def    = 12'(MEAN);
    bus.adc         = 12'd2100;
    model_clear();
    exp_din = 1'b0;

    // Reset holds everything low even with a high ADC level
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_val("rst.din",   32'(bus.din),           32'd0);
    check_val("rst.ready", 32'(bus.data_in_ready), 32'd0);
    check_outputs("rst");
    check_val("rst.pulses", 32'(ready_cycles), 32'd0);

    // Slicer directed and boundary cases, receiver window closed
    @(posedge clk); #1;
    bus.read_en = 1'b0;
    bus.adc     = 12'd2000;
    nrst        = 1'b1;
    slice_check("slc.2070", 2070, MEAN);
    slice_check("slc.2060", 2060, MEAN);
    slice_check("slc.2030", 2030, MEAN);
    slice_check("slc.2040", 2040, MEAN);
    slice_check("slc.sat_hi_lo", 0, 4090);
    slice_check("slc.sat_hi_4095", 4095, 4090);
    slice_check("slc.sat_lo_hi", 4095, 5);
    slice_check("slc.sat_lo_0", 0, 5);
    for (int i = 0; i < 12; i++) begin
      slice_check("slc.rand", int'($urandom_range(1990, 2110)), MEAN);
    end
    slice_check("slc.park", 2000, MEAN);
    @(posedge clk); #1;
    bus.read_en = 1'b1;

    // Reference frames
    run_frame("frm.a5_par0", build(PREAMBLE, 2'b01, 2'b10, 8'hA5, 1'b0, TRAILER));
    run_frame("frm.a5_par1", build(PREAMBLE, 2'b01, 2'b10, 8'hA5, 1'b1, TRAILER));
    run_frame("frm.bad_pre", build(6'b101011, 2'b11, 2'b00, 8'h3C, 1'b0, TRAILER));
    run_frame("frm.after_bad", build(PREAMBLE, 2'b10, 2'b01, 8'h5E, 1'b1, TRAILER));

    // Program change mid-frame clears everything without a pulse
    r0 = ready_cycles;
    hold_bit(1'b0, 3 * BIT_CYCLES);
    send_bits(build(PREAMBLE, 2'b11, 2'b11, 8'hFF, 1'b0, TRAILER), 10);
    @(posedge clk); #1;
    bus.prog = 2'b10;
    hold_bit(1'b0, 4 * BIT_CYCLES);
    @(negedge clk);
    model_clear();
    check_val("prg.din",   32'(bus.din), 32'd0);
    check_val("prg.ready", 32'(ready_cycles - r0), 32'd0);
    check_outputs("prg");
    @(posedge clk); #1;
    bus.prog = 2'b11;
    run_frame("frm.after_prg", build(PREAMBLE, 2'b01, 2'b10, 8'hA5, 1'b0, TRAILER));

    // Closing the window mid-frame drops it and keeps previous results
    r0 = ready_cycles;
    hold_bit(1'b0, 3 * BIT_CYCLES);
    send_bits(build(PREAMBLE, 2'b10, 2'b10, 8'h0F, 1'b0, TRAILER), 20);
    @(posedge clk); #1;
    bus.read_en = 1'b0;
    send_bits(build(PREAMBLE, 2'b10, 2'b10, 8'h0F, 1'b0, TRAILER) << 20, 3);
    hold_bit(1'b0, 4 * BIT_CYCLES);
    @(negedge clk);
    check_val("ren.ready", 32'(ready_cycles - r0), 32'd0);
    check_outputs("ren");
    @(posedge clk); #1;
    bus.read_en = 1'b1;
    run_frame("frm.after_ren", build(PREAMBLE, 2'b00, 2'b11, 8'h81, 1'b1, TRAILER));

    // Link loss acts as a clear
    @(posedge clk); #1;
    bus.swipt_alive = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    model_clear();
    check_outputs("alive");
    @(posedge clk); #1;
    bus.swipt_alive = 1'b1;

    // Randomised frames: good, parity-flipped, bad preamble, bad trailer
    for (int n = 0; n < 20; n++) begin
      kind = int'($urandom_range(0, 3));
      m    = 2'($urandom);
      t    = 2'($urandom);
      d    = 8'($urandom);
      par  = ^d;
      pre  = PREAMBLE;
      trl  = TRAILER;
      if (kind == 1) par = ~par;
      if (kind == 2) begin
        pre = 6'($urandom);
        if (pre == PREAMBLE) pre = 6'b101011;
      end
      if (kind == 3) begin
        trl = 4'($urandom);
        if (trl == TRAILER) trl = 4'b0111;
      end
      f = build(pre, m, t, d, par, trl);
      run_frame($sformatf("rnd%0d.k%0d", n, kind), f);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
